// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM, one micro-step per clock
// Optional MCC_MEM_WAIT_EN adds mem_ready to stall FETCH, MEM_RD and MEM_WR.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MCC_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  input  logic [5:0]         opcode,
  output logic               PCWrite,
  output logic               PCWriteCondEQ,
  output logic               PCWriteCondNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ZeroExt,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  state_t state_q, state_d;
  logic   mem_rdy;

`ifdef MCC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ZeroExt       = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 3'b000;
    PCSource      = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // IR and PC load only on the cycle the fetch data is actually present
        MemRead = 1'b1;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b100;
        state_d = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 3'b100;
        case (opcode)
          OP_LW, OP_SW:            state_d = S_MEM_ADDR;
          OP_R:                    state_d = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
          default:                 state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 3'b100;
        state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_rdy ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_rdy;
        state_d    = mem_rdy ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ZeroExt = (opcode == OP_ORI);
        case (opcode)
          OP_ORI:  ALUOp = 3'b101;
          OP_LUI:  ALUOp = 3'b110;
          default: ALUOp = 3'b100;
        endcase
        state_d = S_WB_I;
      end
      S_WB_I: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 3'b011;
        PCSource      = 2'b01;
        PCWriteCondEQ = (opcode == OP_BEQ);
        PCWriteCondNE = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed checks of the multicycle control FSM
// Stall checks run only when MCC_MEM_WAIT_EN is defined.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic       mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ZeroExt, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;
  int cycles;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MCC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .opcode(opcode),
    .PCWrite(PCWrite),
    .PCWriteCondEQ(PCWriteCondEQ),
    .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .IRWrite(IRWrite),
    .MemtoReg(MemtoReg),
    .RegDst(RegDst),
    .RegWrite(RegWrite),
    .ZeroExt(ZeroExt),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp),
    .PCSource(PCSource),
    .instr_done(instr_done),
    .illegal_op(illegal_op),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] all_outs();
    return {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ZeroExt, ALUSrcA, ALUSrcB, ALUOp, PCSource,
            instr_done, illegal_op};
  endfunction

  // Walks FETCH then DECODE; leaves the bench sitting in DECODE's successor.
  task automatic fetch_decode(input logic [5:0] op, input string name);
    opcode = op;
    check_eq({name, " fetch state"}, 32'(state_o), 32'd1);
    step();
    check_eq({name, " decode state"}, 32'(state_o), 32'd2);
    check_eq({name, " decode ALUSrcB"}, 32'(ALUSrcB), 32'd3);
    step();
  endtask

  initial begin
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b000000;
    repeat (3) step();
    check_eq("reset state", 32'(state_o), 32'd0);
    check_eq("reset outs", 32'(all_outs()), 32'd0);
    reset = 1'b1;
    #2;
    check_eq("idle after release", 32'(state_o), 32'd0);
    step();
    check_eq("fetch state", 32'(state_o), 32'd1);
    check_eq("fetch strobes", 32'({MemRead, IRWrite, PCWrite}), 32'b111);
    check_eq("fetch ALUSrcB", 32'(ALUSrcB), 32'b01);
    check_eq("fetch ALUOp", 32'(ALUOp), 32'b100);

    // R-type
    fetch_decode(6'b000000, "R");
    check_eq("R exec state", 32'(state_o), 32'd7);
    check_eq("R exec ALUOp", 32'(ALUOp), 32'b111);
    check_eq("R exec ALUSrcA", 32'(ALUSrcA), 32'd1);
    step();
    check_eq("R wb state", 32'(state_o), 32'd8);
    check_eq("R wb RegWrite/RegDst/done", 32'({RegWrite, RegDst, instr_done}), 32'b111);
    step();

    // ORI
    fetch_decode(6'b001101, "ORI");
    check_eq("ORI exec state", 32'(state_o), 32'd9);
    check_eq("ORI ALUOp", 32'(ALUOp), 32'b101);
    check_eq("ORI ZeroExt", 32'(ZeroExt), 32'd1);
    check_eq("ORI ALUSrcB", 32'(ALUSrcB), 32'b10);
    step();
    check_eq("ORI wb state", 32'(state_o), 32'd10);
    check_eq("ORI wb RegWrite/RegDst/done", 32'({RegWrite, RegDst, instr_done}), 32'b101);
    step();

    // LUI and ADDI ALUOp selection
    fetch_decode(6'b001111, "LUI");
    check_eq("LUI ALUOp/ZeroExt", 32'({ALUOp, ZeroExt}), 32'b1100);
    step(); step();
    fetch_decode(6'b001000, "ADDI");
    check_eq("ADDI ALUOp/ZeroExt", 32'({ALUOp, ZeroExt}), 32'b1000);
    step(); step();

    // LW: 5 cycles
    fetch_decode(6'b100011, "LW");
    check_eq("LW memaddr state", 32'(state_o), 32'd3);
    check_eq("LW memaddr ALUSrcA/B", 32'({ALUSrcA, ALUSrcB}), 32'b110);
    step();
    check_eq("LW memrd state", 32'(state_o), 32'd4);
    check_eq("LW memrd IorD/MemRead", 32'({IorD, MemRead}), 32'b11);
    step();
    check_eq("LW memwb state", 32'(state_o), 32'd5);
    check_eq("LW memwb MemtoReg/RegWrite/done", 32'({MemtoReg, RegWrite, instr_done}), 32'b111);
    step();

    // BNE
    fetch_decode(6'b000101, "BNE");
    check_eq("BNE state", 32'(state_o), 32'd11);
    check_eq("BNE ALUOp", 32'(ALUOp), 32'b011);
    check_eq("BNE condEQ/condNE", 32'({PCWriteCondEQ, PCWriteCondNE}), 32'b01);
    check_eq("BNE PCSource/done", 32'({PCSource, instr_done}), 32'b011);
    step();

    // BEQ
    fetch_decode(6'b000100, "BEQ");
    check_eq("BEQ condEQ/condNE", 32'({PCWriteCondEQ, PCWriteCondNE}), 32'b10);
    step();

    // J
    fetch_decode(6'b000010, "J");
    check_eq("J state", 32'(state_o), 32'd12);
    check_eq("J PCWrite/PCSource/done", 32'({PCWrite, PCSource, instr_done}), 32'b1101);
    step();

    // illegal opcode
    fetch_decode(6'b111111, "ILL");
    check_eq("ILL state", 32'(state_o), 32'd13);
    check_eq("ILL illegal/done", 32'({illegal_op, instr_done}), 32'b11);
    check_eq("ILL no writes", 32'({RegWrite, MemWrite, PCWrite}), 32'b000);
    step();
    check_eq("ILL back to fetch", 32'(state_o), 32'd1);

    // SW with reset in MEM_WR
    fetch_decode(6'b101011, "SW");
    check_eq("SW memaddr state", 32'(state_o), 32'd3);
    step();
    check_eq("SW memwr state", 32'(state_o), 32'd6);
    check_eq("SW memwr MemWrite/IorD/done", 32'({MemWrite, IorD, instr_done}), 32'b111);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midreset state", 32'(state_o), 32'd0);
    check_eq("midreset MemWrite", 32'(MemWrite), 32'd0);
    check_eq("midreset outs", 32'(all_outs()), 32'd0);
    step();
    reset = 1'b1;
    step();
    check_eq("post reset fetch", 32'(state_o), 32'd1);

`ifdef MCC_MEM_WAIT_EN
    // LW with 3 wait cycles in MEM_RD: 8 cycles total
    cycles = 1;
    opcode = 6'b100011;
    step(); cycles++;
    step(); cycles++;
    step(); cycles++;
    check_eq("wait memrd state", 32'(state_o), 32'd4);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); cycles++;
      check_eq("wait memrd held", 32'(state_o), 32'd4);
      check_eq("wait memrd MemRead/IorD", 32'({MemRead, IorD}), 32'b11);
    end
    mem_ready = 1'b1;
    step(); cycles++;
    check_eq("wait memwb state", 32'(state_o), 32'd5);
    check_eq("wait LW latency", 32'(cycles), 32'd8);
    step();
    // stall in FETCH gates IRWrite and PCWrite
    mem_ready = 1'b0;
    #1;
    check_eq("fetch stall strobes", 32'({MemRead, IRWrite, PCWrite}), 32'b100);
    step();
    check_eq("fetch stall held", 32'(state_o), 32'd1);
    mem_ready = 1'b1;
    #1;
    check_eq("fetch ready strobes", 32'({MemRead, IRWrite, PCWrite}), 32'b111);
    step();
    check_eq("fetch ready advance", 32'(state_o), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
